// File: rtl/posit_defines_es3.sv
// posit_defines_es3: shared posit<32,3> constants and dot-product scheduler types
package posit_defines_es3;
   localparam int NBITS   = 32;
   localparam int MAC_LAT = 6;
   localparam int MAX_LEN = 4096;
   function automatic int len_w(input int max_len);
      return $clog2(max_len + 1);
   endfunction
   localparam int LEN_W = len_w(MAX_LEN);
   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_READ, S_WAIT_RD, S_RESULT
   } sched_state_t;
endpackage

// File: rtl/posit_dot_sched_es3.sv
// posit_dot_sched_es3: sequences one posit<32,3> dot-product job through the MAC and rounding units
//   clk_i, reset_n_i          clock, async active-low reset
//   job_valid_i/job_ready_o   job request handshake, job_len_i = pair count (0 legal)
//   op_valid_i/op_ready_o     operand pair stream, op_a_i/op_b_i
//   mac_clear_o, mac_issue_o  accumulator clear pulse, registered issue with mac_a_o/mac_b_o
//   mac_retire_i              one pulse per completed accumulate
//   rd_start_o, rd_done_i     rounding request pulse, completion with rd_result_i
//   res_valid_o/res_ready_i   result handshake, res_data_o/res_count_o
//   busy_o, err_o             not idle, sticky retire-with-nothing-outstanding
module posit_dot_sched_es3
   import posit_defines_es3::*;
(
   input  logic             clk_i,
   input  logic             reset_n_i,
   input  logic             job_valid_i,
   output logic             job_ready_o,
   input  logic [LEN_W-1:0] job_len_i,
   input  logic             op_valid_i,
   output logic             op_ready_o,
   input  logic [NBITS-1:0] op_a_i,
   input  logic [NBITS-1:0] op_b_i,
   output logic             mac_clear_o,
   output logic             mac_issue_o,
   output logic [NBITS-1:0] mac_a_o,
   output logic [NBITS-1:0] mac_b_o,
   input  logic             mac_retire_i,
   output logic             rd_start_o,
   input  logic             rd_done_i,
   input  logic [NBITS-1:0] rd_result_i,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [NBITS-1:0] res_data_o,
   output logic [LEN_W-1:0] res_count_o,
   output logic             busy_o,
   output logic             err_o
);
   sched_state_t     state_q;
   logic [LEN_W-1:0] len_q, issued_q, retired_q, issued_d, retired_d, outstanding, res_count_q;
   logic [NBITS-1:0] mac_a_q, mac_b_q, res_data_q;
   logic             mac_clear_q, mac_issue_q, rd_start_q, res_valid_q, err_q;
   logic             op_hs, ret_ok, ret_bad;

   assign op_ready_o  = state_q == S_STREAM && issued_q < len_q;
   assign op_hs       = op_valid_i && op_ready_o;
   assign outstanding = issued_q - retired_q;
   // a retire with nothing in flight is flagged and never counted
   assign ret_ok      = mac_retire_i && outstanding != '0;
   assign ret_bad     = mac_retire_i && outstanding == '0;
   assign issued_d    = issued_q + LEN_W'(op_hs);
   assign retired_d   = retired_q + LEN_W'(ret_ok);

   assign job_ready_o = reset_n_i && state_q == S_IDLE;
   assign busy_o      = state_q != S_IDLE;
   assign mac_clear_o = mac_clear_q;
   assign mac_issue_o = mac_issue_q;
   assign mac_a_o     = mac_a_q;
   assign mac_b_o     = mac_b_q;
   assign rd_start_o  = rd_start_q;
   assign res_valid_o = res_valid_q;
   assign res_data_o  = res_data_q;
   assign res_count_o = res_count_q;
   assign err_o       = err_q;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         issued_q    <= '0;
         retired_q   <= '0;
         mac_clear_q <= 1'b0;
         mac_issue_q <= 1'b0;
         mac_a_q     <= '0;
         mac_b_q     <= '0;
         rd_start_q  <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_count_q <= '0;
         err_q       <= 1'b0;
      end else begin
         issued_q    <= issued_d;
         retired_q   <= retired_d;
         err_q       <= err_q | ret_bad;
         mac_issue_q <= op_hs;
         mac_clear_q <= 1'b0;
         rd_start_q  <= 1'b0;
         if (op_hs) begin
            mac_a_q <= op_a_i;
            mac_b_q <= op_b_i;
         end
         case (state_q)
            S_IDLE: if (job_valid_i) begin
               len_q       <= job_len_i;
               issued_q    <= '0;
               retired_q   <= '0;
               err_q       <= 1'b0;
               mac_clear_q <= 1'b1;
               state_q     <= S_CLEAR;
            end
            S_CLEAR: begin
               // an empty job goes straight to reading the freshly cleared accumulator
               state_q    <= len_q != '0 ? S_STREAM : S_READ;
               rd_start_q <= len_q == '0;
            end
            S_STREAM: if (op_hs && issued_d == len_q) state_q <= S_DRAIN;
            // looking at the next retire count lets rd_start follow the last retire by one cycle
            S_DRAIN: if (retired_d == len_q) begin
               state_q    <= S_READ;
               rd_start_q <= 1'b1;
            end
            S_READ: state_q <= S_WAIT_RD;
            S_WAIT_RD: if (rd_done_i) begin
               res_data_q  <= rd_result_i;
               res_count_q <= len_q;
               res_valid_q <= 1'b1;
               state_q     <= S_RESULT;
            end
            S_RESULT: if (res_ready_i) begin
               res_valid_q <= 1'b0;
               state_q     <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_posit_dot_sched_es3.sv
// tb_posit_dot_sched_es3: self-checking bench for the posit dot-product scheduler
module tb_posit_dot_sched_es3;
   import posit_defines_es3::*;

   logic             clk = 1'b0, reset_n = 1'b0;
   logic             job_valid = 1'b0, op_valid = 1'b0, res_ready = 1'b0;
   logic [LEN_W-1:0] job_len = '0;
   logic [NBITS-1:0] op_a = '0, op_b = '0;
   logic             mac_retire = 1'b0, rd_done = 1'b0, force_ret = 1'b0;
   logic [NBITS-1:0] rd_result = '0;
   logic             job_ready, op_ready, mac_clear, mac_issue, rd_start, res_valid, busy, err;
   logic [NBITS-1:0] mac_a, mac_b, res_data;
   logic [LEN_W-1:0] res_count;

   posit_dot_sched_es3 dut (
      .clk_i(clk), .reset_n_i(reset_n), .job_valid_i(job_valid), .job_ready_o(job_ready),
      .job_len_i(job_len), .op_valid_i(op_valid), .op_ready_o(op_ready), .op_a_i(op_a),
      .op_b_i(op_b), .mac_clear_o(mac_clear), .mac_issue_o(mac_issue), .mac_a_o(mac_a),
      .mac_b_o(mac_b), .mac_retire_i(mac_retire), .rd_start_o(rd_start), .rd_done_i(rd_done),
      .rd_result_i(rd_result), .res_valid_o(res_valid), .res_ready_i(res_ready),
      .res_data_o(res_data), .res_count_o(res_count), .busy_o(busy), .err_o(err)
   );

   always #5 clk = ~clk;

   typedef struct {int len; bit toggle; int hold; int lat; int extra; logic [31:0] rd; int exp_cnt;} rec_t;
   typedef struct {logic [31:0] a; logic [31:0] b;} op_t;
   typedef struct {logic [31:0] data; logic [LEN_W-1:0] cnt;} res_t;

   rec_t        tbl[6];
   op_t         opq[$];
   res_t        sb[$];
   int          retq[$];
   op_t         o;
   res_t        e;
   int          n_cmp = 0, n_fail = 0, cyc = 0;
   int          cur_len = 0, cur_lat = 6, cur_extra = 0, cur_exp = 0;
   int          n_issue = 0, n_clear = 0, n_rst = 0, n_hs = 0, iss0 = 0, clr0 = 0, rst0 = 0, hs0 = 0;
   int          first_iss = 0, last_iss = 0, last_ret = 0, clear_cyc = 0, rd_at = -1;
   logic [31:0] rd_val = '0;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      n_cmp++;
      n_fail++;
      $display("FAIL %s", nm);
   endtask

   // MAC/rounding models plus operand and result scoreboards, sampled just after the falling edge
   always @(negedge clk) begin
      #1;
      if (!reset_n) begin
         opq.delete();
         retq.delete();
         sb.delete();
         mac_retire = 1'b0;
         rd_done = 1'b0;
      end else begin
         mac_retire = force_ret || (retq.size() > 0 && retq[0] == cyc);
         if (retq.size() > 0 && retq[0] == cyc) begin
            void'(retq.pop_front());
            last_ret = cyc;
         end
         if (mac_issue) begin
            n_issue++;
            if (n_issue - iss0 == 1) first_iss = cyc;
            last_iss = cyc;
            if (opq.size() == 0) fail_now("mac_issue_without_operand");
            else begin
               o = opq.pop_front();
               chk("mac_a", mac_a, o.a);
               chk("mac_b", mac_b, o.b);
            end
            retq.push_back(cyc + cur_lat + ((n_issue - iss0 == cur_len) ? cur_extra : 0));
         end
         if (op_valid && op_ready) begin
            o.a = op_a;
            o.b = op_b;
            opq.push_back(o);
            n_hs++;
         end
         if (job_valid && job_ready) begin
            e.data = rd_val;
            e.cnt = LEN_W'(cur_exp);
            sb.push_back(e);
         end
         if (mac_clear) begin
            n_clear++;
            clear_cyc = cyc;
         end
         if (rd_start) begin
            n_rst++;
            chk("rd_start_cycle", cyc, cur_len > 0 ? last_ret + 1 : clear_cyc + 1);
            rd_at = cyc + 3;
         end
         rd_done = cyc == rd_at;
         rd_result = rd_done ? rd_val : $urandom;
         if (res_valid) begin
            if (sb.size() == 0) fail_now("res_valid_without_job");
            else if (res_ready) begin
               e = sb.pop_front();
               chk("res_data", res_data, e.data);
               chk("res_count", 32'(res_count), 32'(e.cnt));
            end else chk("res_hold", res_data, sb[0].data);
         end
      end
   end

   task automatic start_job(input rec_t r);
      int t = 0;
      @(negedge clk);
      while (!job_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!job_ready) fail_now("job_ready_timeout");
      cur_len = r.len;
      cur_lat = r.lat;
      cur_extra = r.extra;
      cur_exp = r.exp_cnt;
      rd_val = r.rd;
      iss0 = n_issue;
      clr0 = n_clear;
      rst0 = n_rst;
      hs0 = n_hs;
      job_valid = 1'b1;
      job_len = LEN_W'(r.len);
      @(negedge clk);
      job_valid = 1'b0;
   endtask

   task automatic stream(input bit toggle, input int cnt);
      int t = 0;
      while (n_hs - hs0 < cnt && t < 200) begin
         op_valid = toggle ? (t % 2 == 0) : 1'b1;
         op_a = $urandom;
         op_b = $urandom;
         t++;
         #2;
         if (n_hs - hs0 < cnt) @(negedge clk);
      end
      if (n_hs - hs0 < cnt) fail_now("stream_timeout");
      @(negedge clk);
      op_valid = 1'b0;
   endtask

   task automatic run_job(input rec_t r);
      int t = 0;
      start_job(r);
      stream(r.toggle, r.len);
      while (!res_valid && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!res_valid) fail_now("res_valid_timeout");
      repeat (r.hold) @(negedge clk);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      #2;
      chk("job_ready_after_res", 32'(job_ready), 1);
      chk("res_valid_dropped", 32'(res_valid), 0);
      chk("issue_count", n_issue - iss0, r.exp_cnt);
      chk("clear_count", n_clear - clr0, 1);
      chk("rd_start_count", n_rst - rst0, 1);
      chk("err_clean", 32'(err), 0);
      if (!r.toggle && r.len > 0) chk("issue_consecutive", last_iss - first_iss, r.len - 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog_timeout");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{len: 4,  toggle: 0, hold: 0, lat: 6, extra: 0, rd: 32'h4000_0000, exp_cnt: 4};
      tbl[1] = '{len: 0,  toggle: 0, hold: 0, lat: 6, extra: 0, rd: 32'h0000_0000, exp_cnt: 0};
      tbl[2] = '{len: 8,  toggle: 1, hold: 5, lat: 6, extra: 0, rd: 32'h3C00_1234, exp_cnt: 8};
      tbl[3] = '{len: 8,  toggle: 0, hold: 0, lat: 2, extra: 4, rd: 32'h5A5A_A5A5, exp_cnt: 8};
      tbl[4] = '{len: 3,  toggle: 0, hold: 1, lat: 4, extra: 0, rd: 32'h7F00_0001, exp_cnt: 3};
      tbl[5] = '{len: 2,  toggle: 0, hold: 0, lat: 6, extra: 0, rd: 32'hC000_0000, exp_cnt: 2};
      repeat (3) @(negedge clk);
      #2;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_job_ready", 32'(job_ready), 0);
      chk("rst_op_ready", 32'(op_ready), 0);
      chk("rst_mac_clear", 32'(mac_clear), 0);
      chk("rst_mac_issue", 32'(mac_issue), 0);
      chk("rst_rd_start", 32'(rd_start), 0);
      chk("rst_res_valid", 32'(res_valid), 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_err", 32'(err), 0);
      @(negedge clk);
      reset_n = 1'b1;
      #2;
      chk("job_ready_after_reset", 32'(job_ready), 1);
      for (int i = 0; i < 4; i++) run_job(tbl[i]);
      // stray retire while idle sets err, which sticks until the next job is accepted
      @(negedge clk);
      force_ret = 1'b1;
      @(negedge clk);
      force_ret = 1'b0;
      #2;
      chk("err_set", 32'(err), 1);
      repeat (3) @(negedge clk);
      #2;
      chk("err_sticky", 32'(err), 1);
      run_job(tbl[4]);
      // reset in the middle of a 10-pair job after 3 pairs are accepted
      start_job('{len: 10, toggle: 0, hold: 0, lat: 6, extra: 0, rd: 32'h1111_1111, exp_cnt: 10});
      stream(1'b0, 3);
      reset_n = 1'b0;
      #2;
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_op_ready", 32'(op_ready), 0);
      chk("midrst_mac_issue", 32'(mac_issue), 0);
      chk("midrst_mac_a", mac_a, 0);
      chk("midrst_res_valid", 32'(res_valid), 0);
      @(negedge clk);
      reset_n = 1'b1;
      #2;
      chk("midrst_job_ready", 32'(job_ready), 1);
      run_job(tbl[5]);
      repeat (5) @(negedge clk);
      chk("no_leftover_results", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
